// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter:
// function codes and response-stage state encoding.
package alu_pkg;

  localparam int unsigned FUNC_W = 3;

  localparam logic [FUNC_W-1:0] ALU_ADD  = 3'd0;
  localparam logic [FUNC_W-1:0] ALU_SUB  = 3'd1;
  localparam logic [FUNC_W-1:0] ALU_AND  = 3'd2;
  localparam logic [FUNC_W-1:0] ALU_OR   = 3'd3;
  localparam logic [FUNC_W-1:0] ALU_NOR  = 3'd4;
  localparam logic [FUNC_W-1:0] ALU_SLT  = 3'd5;
  localparam logic [FUNC_W-1:0] ALU_PASS = 3'd6;
  localparam logic [FUNC_W-1:0] ALU_ZERO = 3'd7;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU shared by both requesters; arithmetic wraps, SLT is unsigned.
module alu_share_arbiter_alu
  import alu_pkg::*;
#(
  parameter int unsigned size   = 32,
  parameter int unsigned func_w = alu_pkg::FUNC_W
) (
  input  logic [size-1:0]   a,
  input  logic [size-1:0]   b,
  input  logic [func_w-1:0] func,
  output logic [size-1:0]   out,
  output logic              zero_flag
);

  always_comb begin
    out = '0;
    case (func)
      func_w'(ALU_ADD):  out = a + b;
      func_w'(ALU_SUB):  out = a - b;
      func_w'(ALU_AND):  out = a & b;
      func_w'(ALU_OR):   out = a | b;
      func_w'(ALU_NOR):  out = ~(a | b);
      func_w'(ALU_SLT):  out = size'(a < b);
      func_w'(ALU_PASS): out = b;
      default:           out = '0;
    endcase
  end

  assign zero_flag = (out == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters with a
// single registered result stage that supports back-to-back issue.
module alu_share_arbiter #(
  parameter int unsigned SIZE   = 32,
  parameter int unsigned FUNC_W = alu_pkg::FUNC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [SIZE-1:0]   req0_a,
  input  logic [SIZE-1:0]   req0_b,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [SIZE-1:0]   req1_a,
  input  logic [SIZE-1:0]   req1_b,
  input  logic [FUNC_W-1:0] req1_func,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [SIZE-1:0]   rsp_out,
  output logic              rsp_zero,
  output logic              rsp_id
);
  import alu_pkg::*;

  state_t            state_q, state_d;
  logic              rr_ptr_q;
  logic              can_accept;
  logic              grant;
  logic              accept;
  logic [SIZE-1:0]   op_a, op_b;
  logic [FUNC_W-1:0] op_func;
  logic [SIZE-1:0]   alu_out;
  logic              alu_zero;

  // Grant: a lone requester wins; under contention the round-robin pointer decides.
  always_comb begin
    grant = rr_ptr_q;
    if (req0_valid && !req1_valid) grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
  end

  assign can_accept = !reset && ((state_q == ST_EMPTY) || rsp_ready);
  assign req0_ready = can_accept && (grant == 1'b0);
  assign req1_ready = can_accept && (grant == 1'b1);
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign op_a    = grant ? req1_a    : req0_a;
  assign op_b    = grant ? req1_b    : req0_b;
  assign op_func = grant ? req1_func : req0_func;

  alu_share_arbiter_alu #(
    .size  (SIZE),
    .func_w(FUNC_W)
  ) u_alu (
    .a        (op_a),
    .b        (op_b),
    .func     (op_func),
    .out      (alu_out),
    .zero_flag(alu_zero)
  );

  // Result-stage occupancy: an accept always fills, a drain without accept empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (rsp_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= 1'b0;
      rsp_out  <= '0;
      rsp_zero <= 1'b0;
      rsp_id   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rr_ptr_q <= ~rr_ptr_q;
        rsp_out  <= alu_out;
        rsp_zero <= alu_zero;
        rsp_id   <= grant;
      end
    end
  end

  assign rsp_valid = (state_q == ST_FULL);

  // A pending request must hold its valid and payload until it is taken.
  a_req0_hold: assert property (@(posedge clk) disable iff (reset)
    (req0_valid && !req0_ready) |=> (req0_valid && $stable(req0_a) &&
                                     $stable(req0_b) && $stable(req0_func)));
  a_req1_hold: assert property (@(posedge clk) disable iff (reset)
    (req1_valid && !req1_ready) |=> (req1_valid && $stable(req1_a) &&
                                     $stable(req1_b) && $stable(req1_func)));

endmodule
